// File: rtl/divider_if.sv
// Handshake and data bundle between a divider client and the divider.
//   start     : one-cycle request, operands sampled with it
//   dividend  : signed numerator
//   divisor   : signed denominator
//   out / rem : signed quotient (truncated toward zero) and remainder
//   ready     : one-cycle pulse when out/rem/exception are valid
//   busy      : division in progress
//   exception : divide-by-zero or overflow, valid with ready
interface divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rem;
  logic             ready;
  logic             busy;
  logic             exception;

  modport master (
    output start, dividend, divisor,
    input  out, rem, ready, busy, exception
  );

  modport slave (
    input  start, dividend, divisor,
    output out, rem, ready, busy, exception
  );
endinterface

// File: rtl/divider.sv
// Sequential signed divider: radix-2 restoring division on operand
// magnitudes, one quotient bit per cycle, sign correction on completion.
// Fixed latency of WIDTH cycles from the start edge to the ready pulse.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides everything
//   bus : divider_if slave (start/operands in, results/flags out)
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] a_q, a_n;      // partial remainder
  logic [WIDTH-1:0] q_q, q_n;      // quotient / shifted-out dividend magnitude
  logic [WIDTH-1:0] d_q, d_n;      // divisor magnitude
  logic             sign_q, sign_q_n;
  logic             sign_r, sign_r_n;
  logic             div0, div0_n;
  logic             ovf, ovf_n;
  logic [WIDTH-1:0] out_q, out_n;
  logic [WIDTH-1:0] rem_q, rem_n;
  logic             ready_q, ready_n;
  logic             busy_q, busy_n;
  logic             exc_q, exc_n;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] a_it, q_it;
  logic             start_ok;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    // The most negative value maps onto 2^(WIDTH-1), which is exact unsigned.
    return x[WIDTH-1] ? -x : x;
  endfunction

  // One restoring step. The stored remainder is always below the divisor,
  // so the shifted value fits in WIDTH+1 bits and t's MSB is a true sign.
  always_comb begin
    a_sh = {a_q, q_q[WIDTH-1]};
    t    = a_sh - {1'b0, d_q};
    q_it = {q_q[WIDTH-2:0], ~t[WIDTH]};
    a_it = t[WIDTH] ? a_sh[WIDTH-1:0] : t[WIDTH-1:0];
  end

  assign start_ok = bus.start && (state != RUN);

  // Next-state, datapath and output logic.
  always_comb begin
    state_n  = state;
    count_n  = count;
    a_n      = a_q;
    q_n      = q_q;
    d_n      = d_q;
    sign_q_n = sign_q;
    sign_r_n = sign_r;
    div0_n   = div0;
    ovf_n    = ovf;
    out_n    = out_q;
    rem_n    = rem_q;
    exc_n    = exc_q;
    ready_n  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) state_n = RUN;
      end
      RUN: begin
        a_n     = a_it;
        q_n     = q_it;
        count_n = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          state_n = DONE;
          ready_n = 1'b1;
          exc_n   = div0 | ovf;
          // With a zero divisor every trial succeeds, so the remainder ends
          // up holding |dividend| and sign correction restores the dividend.
          if (div0)
            out_n = '0;
          else if (ovf)
            out_n = {1'b1, {(WIDTH-1){1'b0}}};
          else
            out_n = sign_q ? -q_it : q_it;
          if (ovf)
            rem_n = '0;
          else
            rem_n = sign_r ? -a_it : a_it;
        end
      end
      DONE: begin
        state_n = bus.start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (start_ok) begin
      a_n      = '0;
      q_n      = mag(bus.dividend);
      d_n      = mag(bus.divisor);
      count_n  = '0;
      sign_q_n = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      sign_r_n = bus.dividend[WIDTH-1];
      div0_n   = (bus.divisor == '0);
      ovf_n    = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.divisor == '1);
    end

    busy_n = (state_n == RUN);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
      out_q   <= '0;
      rem_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      a_q     <= a_n;
      q_q     <= q_n;
      d_q     <= d_n;
      sign_q  <= sign_q_n;
      sign_r  <= sign_r_n;
      div0    <= div0_n;
      ovf     <= ovf_n;
      out_q   <= out_n;
      rem_q   <= rem_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
      exc_q   <= exc_n;
    end
  end

  assign bus.out       = out_q;
  assign bus.rem       = rem_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.exception = exc_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus random operands,
// compared against plain signed integer arithmetic.
module tb_divider;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 32;
  localparam int MIN_INT = int'(32'h8000_0000);

  logic clk = 1'b0;
  logic rst = 1'b1;

  divider_if #(.WIDTH(WIDTH)) bus ();

  divider #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;
  int bcnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.busy === 1'b1) bcnt++;
  endtask

  // Reference: C-style truncating division with the two special cases.
  function automatic void ref_div(input int a, input int b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
    if (b == 0) begin
      q = 32'd0; r = 32'(a); e = 1'b1;
    end else if (a == MIN_INT && b == -1) begin
      q = 32'h8000_0000; r = 32'd0; e = 1'b1;
    end else begin
      q = 32'(a / b); r = 32'(a % b); e = 1'b0;
    end
  endfunction

  task automatic do_start(input int a, input int b);
    bcnt = 0;
    bus.start    = 1'b1;
    bus.dividend = 32'(a);
    bus.divisor  = 32'(b);
    step();
    t0 = cyc;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
  endtask

  task automatic expect_result(input int a, input int b, input string tag);
    logic [31:0] q, r;
    logic e;
    ref_div(a, b, q, r, e);
    check({tag, ".ready"}, 32'(bus.ready), 32'd1);
    check({tag, ".latency"}, 32'(cyc - t0), 32'(LATENCY));
    check({tag, ".busy_cycles"}, 32'(bcnt), 32'(LATENCY));
    check({tag, ".out"}, bus.out, q);
    check({tag, ".rem"}, bus.rem, r);
    check({tag, ".exception"}, 32'(bus.exception), 32'(e));
  endtask

  task automatic run(input int a, input int b, input string tag);
    do_start(a, b);
    wait_ready();
    expect_result(a, b, tag);
    check({tag, ".busy_at_ready"}, 32'(bus.busy), 32'd0);
    step();
    check({tag, ".ready_one_cycle"}, 32'(bus.ready), 32'd0);
  endtask

  initial begin
    int a, b;
    bit saw_ready;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset state
    step();
    step();
    check("rst.out", bus.out, 32'd0);
    check("rst.rem", bus.rem, 32'd0);
    check("rst.ready", 32'(bus.ready), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.exception", 32'(bus.exception), 32'd0);
    rst = 1'b0;
    step();

    // Sign combinations
    run(100, 7, "pos_pos");
    run(-100, 7, "neg_pos");
    run(100, -7, "pos_neg");
    run(-100, -7, "neg_neg");

    // Divide by zero, then results/flags hold while the next divide runs
    run(5, 0, "div0");
    do_start(6, 3);
    check("hold.out", bus.out, 32'd0);
    check("hold.rem", bus.rem, 32'd5);
    check("hold.exception", 32'(bus.exception), 32'd1);
    wait_ready();
    expect_result(6, 3, "after_div0");
    step();

    // Overflow and most-negative dividend
    run(MIN_INT, -1, "ovf");
    run(MIN_INT, 1, "min_by_1");
    run(-5, 0, "div0_neg");

    // start while busy is ignored
    do_start(1000, 3);
    repeat (9) step();
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    step();
    bus.start = 1'b0;
    wait_ready();
    expect_result(1000, 3, "ignore_start");
    step();

    // Reset mid-run
    do_start(1000, 3);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.ready", 32'(bus.ready), 32'd0);
    check("midrst.out", bus.out, 32'd0);
    check("midrst.rem", bus.rem, 32'd0);
    check("midrst.exception", 32'(bus.exception), 32'd0);
    saw_ready = 1'b0;
    repeat (40) begin
      step();
      if (bus.ready === 1'b1) saw_ready = 1'b1;
    end
    check("midrst.no_ready", 32'(saw_ready), 32'd0);
    run(7, -2, "after_rst");

    // Back-to-back: second start in the ready cycle
    do_start(9, 2);
    wait_ready();
    expect_result(9, 2, "b2b_first");
    bcnt = 0;
    bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'hFFFF_FFFD;
    step();
    t0 = cyc;
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
    check("b2b.busy_immediate", 32'(bus.busy), 32'd1);
    check("b2b.out_held", bus.out, 32'd4);
    wait_ready();
    expect_result(9, -3, "b2b_second");
    step();

    // Random operands
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom);
      case ($urandom_range(0, 5))
        0: b = int'($urandom_range(1, 20));
        1: b = -int'($urandom_range(1, 20));
        2: b = 0;
        3: begin a = int'($urandom_range(0, 1000)); b = int'($urandom); end
        default: b = int'($urandom);
      endcase
      run(a, b, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
